// File: rtl/masked_share_compress.sv
`default_nettype none
// ============================================================================
// Module      : masked_share_compress
// Description : Two-stage compression of cross-share terms for a 3-share
//               masked multiplier. Stage 1 registers the raw terms as a
//               glitch barrier; stage 2 XOR-compresses the nine terms of each
//               coordinate into three output shares. A 32-bit Galois LFSR
//               supplies fresh refresh bits and advances once per accepted
//               vector.
// Ports       : clk, rst_n (async, active-low)
//               in_valid / in_ready / in_terms [9*NCOORD]  - term vector input
//               rand_out [3*NCOORD]                       - refresh bits
//               seed_load / seed [32]                     - LFSR reseed
//               out_valid / out_ready                     - output handshake
//               out_share1..3 [NCOORD]                    - compressed shares
// Revision    : 1.0 - initial release
// ============================================================================
module masked_share_compress #(
    parameter int          NCOORD    = 4,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [9*NCOORD-1:0]   in_terms,
    output logic [3*NCOORD-1:0]   rand_out,
    input  logic                  seed_load,
    input  logic [31:0]           seed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCOORD-1:0]     out_share1,
    output logic [NCOORD-1:0]     out_share2,
    output logic [NCOORD-1:0]     out_share3
);

    // Right-shifting Galois taps for x^32 + x^22 + x^2 + x + 1
    // (exponent e maps to bit e-1).
    localparam logic [31:0] c_lfsr_taps = 32'h8020_0003;

    logic                 s1_valid_q, s1_valid_d;
    logic [9*NCOORD-1:0]  s1_terms_q, s1_terms_d;
    logic                 out_valid_q, out_valid_d;
    logic [NCOORD-1:0]    share1_q, share1_d;
    logic [NCOORD-1:0]    share2_q, share2_d;
    logic [NCOORD-1:0]    share3_q, share3_d;
    logic [31:0]          lfsr_q, lfsr_d;

    logic                 w_accept;
    logic                 w_s2_load;
    logic [NCOORD-1:0]    w_cmp1, w_cmp2, w_cmp3;

    // Stage 2 may load when stage 1 holds data and the output register is
    // either empty or being drained this cycle.
    assign w_s2_load = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || w_s2_load;
    assign w_accept  = in_valid && in_ready;

    // Compression reads stage-1 flops only, so no input glitch can combine
    // shares of the same secret.
    generate
        for (genvar k = 0; k < NCOORD; k++) begin : g_coord
            assign w_cmp1[k] = ^s1_terms_q[9*k+0 +: 3];
            assign w_cmp2[k] = ^s1_terms_q[9*k+3 +: 3];
            assign w_cmp3[k] = ^s1_terms_q[9*k+6 +: 3];
        end
    endgenerate

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_terms_d  = s1_terms_q;
        out_valid_d = out_valid_q;
        share1_d    = share1_q;
        share2_d    = share2_q;
        share3_d    = share3_q;
        lfsr_d      = lfsr_q;

        if (w_accept) begin
            s1_valid_d = 1'b1;
            s1_terms_d = in_terms;
        end else if (w_s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (w_s2_load) begin
            out_valid_d = 1'b1;
            share1_d    = w_cmp1;
            share2_d    = w_cmp2;
            share3_d    = w_cmp3;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Reseed wins over the per-acceptance step; a zero seed would lock
        // the LFSR, so it is replaced by the default seed.
        if (seed_load) begin
            lfsr_d = (seed == 32'h0) ? LFSR_SEED : seed;
        end else if (w_accept) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? c_lfsr_taps : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_terms_q  <= '0;
            out_valid_q <= 1'b0;
            share1_q    <= '0;
            share2_q    <= '0;
            share3_q    <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_terms_q  <= s1_terms_d;
            out_valid_q <= out_valid_d;
            share1_q    <= share1_d;
            share2_q    <= share2_d;
            share3_q    <= share3_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign rand_out   = lfsr_q[3*NCOORD-1:0];
    assign out_valid  = out_valid_q;
    assign out_share1 = share1_q;
    assign out_share2 = share2_q;
    assign out_share3 = share3_q;

endmodule
`default_nettype wire

// File: tb/tb_masked_share_compress.sv
`default_nettype none
// ============================================================================
// Module      : tb_masked_share_compress
// Description : Directed self-checking bench for masked_share_compress.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_masked_share_compress;

    localparam int          NC    = 4;
    localparam logic [31:0] SEED0 = 32'hACE1_2468;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               in_valid  = 1'b0;
    logic [9*NC-1:0]    in_terms  = '0;
    logic               seed_load = 1'b0;
    logic [31:0]        seed      = '0;
    logic               out_ready = 1'b1;
    logic               in_ready;
    logic               out_valid;
    logic [3*NC-1:0]    rand_out;
    logic [NC-1:0]      sh1, sh2, sh3;

    int                 n_cmp  = 0;
    int                 n_fail = 0;
    logic [31:0]        sw_lfsr;

    masked_share_compress #(.NCOORD(NC), .LFSR_SEED(SEED0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_terms   (in_terms),
        .rand_out   (rand_out),
        .seed_load  (seed_load),
        .seed       (seed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_share1 (sh1),
        .out_share2 (sh2),
        .out_share3 (sh3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Returns {share3, share2, share1}.
    function automatic logic [3*NC-1:0] xor_model(input logic [9*NC-1:0] t);
        logic [3*NC-1:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) begin
            r[k]        = t[9*k+0] ^ t[9*k+1] ^ t[9*k+2];
            r[NC+k]     = t[9*k+3] ^ t[9*k+4] ^ t[9*k+5];
            r[2*NC+k]   = t[9*k+6] ^ t[9*k+7] ^ t[9*k+8];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if ({sh3, sh2, sh1} !== 12'h000) begin n_fail++; $display("FAIL reset_shares: got %h want 000", {sh3, sh2, sh1}); end
        n_cmp++; if (dut.lfsr_q !== SEED0) begin n_fail++; $display("FAIL reset_lfsr: got %h want %h", dut.lfsr_q, SEED0); end
        n_cmp++; if (rand_out !== 12'h468) begin n_fail++; $display("FAIL reset_rand_out: got %h want 468", rand_out); end
        rst_n   = 1'b1;
        sw_lfsr = SEED0;
        tick;
    endtask

    task automatic test_single;
        logic [9*NC-1:0] t;
        t        = '0;
        t[8:0]   = 9'h1FF;
        out_ready = 1'b1;
        in_terms = t;
        in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        tick;
        sw_lfsr  = lfsr_step(sw_lfsr);
        in_valid = 1'b0;
        in_terms = '0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_cycle1_valid: got %b want 0", out_valid); end
        n_cmp++; if (rand_out !== sw_lfsr[11:0]) begin n_fail++; $display("FAIL single_rand_out: got %h want %h", rand_out, sw_lfsr[11:0]); end
        tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_cycle2_valid: got %b want 1", out_valid); end
        n_cmp++; if ({sh3, sh2, sh1} !== {4'b0001, 4'b0001, 4'b0001}) begin n_fail++; $display("FAIL single_shares: got %h want 111", {sh3, sh2, sh1}); end
        tick;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_patterns;
        logic [9*NC-1:0] pv  [2];
        logic [3*NC-1:0] exp [2];
        pv[0] = '0; pv[0][9] = 1'b1; pv[0][12] = 1'b1; pv[0][15] = 1'b1;
        exp[0] = {4'b0010, 4'b0010, 4'b0010};
        pv[1] = '0; pv[1][19] = 1'b1; pv[1][20] = 1'b1;
        exp[1] = {4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 2; i++) begin
            in_terms = pv[i];
            in_valid = 1'b1;
            tick;
            sw_lfsr  = lfsr_step(sw_lfsr);
            in_valid = 1'b0;
            tick;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pattern%0d_valid: got %b want 1", i, out_valid); end
            n_cmp++; if ({sh3, sh2, sh1} !== exp[i]) begin n_fail++; $display("FAIL pattern%0d_shares: got %h want %h", i, {sh3, sh2, sh1}, exp[i]); end
        end
        n_cmp++; if (sh1[2] !== 1'b0) begin n_fail++; $display("FAIL pattern1_share1_bit2: got %b want 0", sh1[2]); end
        tick;
    endtask

    task automatic test_stall;
        logic [9*NC-1:0] vec [3];
        int idx;
        int oidx;
        vec[0] = 36'h1_2345_6789;
        vec[1] = 36'hF_0F0F_1357;
        vec[2] = 36'h8_ACE1_2468;
        idx    = 0;
        oidx   = 0;
        for (int c = 0; c < 13; c++) begin
            out_ready = (c >= 5);
            in_valid  = (idx < 3);
            in_terms  = (idx < 3) ? vec[idx] : '0;
            #1;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (oidx > 2 || {sh3, sh2, sh1} !== xor_model(vec[oidx > 2 ? 2 : oidx])) begin
                    n_fail++; $display("FAIL stall_out%0d: got %h want %h", oidx, {sh3, sh2, sh1}, xor_model(vec[oidx > 2 ? 2 : oidx]));
                end
                oidx++;
            end
            if (in_valid && in_ready) begin
                idx++;
                sw_lfsr = lfsr_step(sw_lfsr);
            end
            if (c == 4) begin
                n_cmp++; if (idx !== 2) begin n_fail++; $display("FAIL stall_accepted: got %0d want 2", idx); end
                n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
                n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_held_valid: got %b want 1", out_valid); end
                n_cmp++; if ({sh3, sh2, sh1} !== xor_model(vec[0])) begin n_fail++; $display("FAIL stall_held_shares: got %h want %h", {sh3, sh2, sh1}, xor_model(vec[0])); end
            end
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++; if (oidx !== 3) begin n_fail++; $display("FAIL stall_out_count: got %0d want 3", oidx); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup: got %b want 0", out_valid); end
        n_cmp++; if (rand_out !== sw_lfsr[11:0]) begin n_fail++; $display("FAIL stall_rand_out: got %h want %h", rand_out, sw_lfsr[11:0]); end
    endtask

    task automatic test_back_to_back;
        logic [9*NC-1:0] v [100];
        logic [63:0] r;
        int oidx;
        for (int i = 0; i < 100; i++) begin
            r    = {$urandom(), $urandom()};
            v[i] = r[9*NC-1:0];
        end
        oidx      = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 103; i++) begin
            in_valid = (i < 100);
            in_terms = (i < 100) ? v[i] : '0;
            #1;
            if (i < 100) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, in_ready); end
            end
            if (in_valid && in_ready) sw_lfsr = lfsr_step(sw_lfsr);
            if (out_valid) begin
                n_cmp++;
                if (oidx > 99 || {sh3, sh2, sh1} !== xor_model(v[oidx > 99 ? 99 : oidx])) begin
                    n_fail++; $display("FAIL b2b_out%0d: got %h want %h", oidx, {sh3, sh2, sh1}, xor_model(v[oidx > 99 ? 99 : oidx]));
                end
                oidx++;
            end
            tick;
            n_cmp++; if (rand_out !== sw_lfsr[11:0]) begin n_fail++; $display("FAIL b2b_rand%0d: got %h want %h", i, rand_out, sw_lfsr[11:0]); end
        end
        in_valid = 1'b0;
        n_cmp++; if (oidx !== 100) begin n_fail++; $display("FAIL b2b_out_count: got %0d want 100", oidx); end
    endtask

    task automatic test_reseed;
        logic [9*NC-1:0] t;
        t         = 36'h5_A5A5_1234;
        out_ready = 1'b1;
        seed      = 32'h0;
        seed_load = 1'b1;
        in_terms  = t;
        in_valid  = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reseed_in_ready: got %b want 1", in_ready); end
        tick;
        seed_load = 1'b0;
        in_valid  = 1'b0;
        sw_lfsr   = SEED0;
        n_cmp++; if (dut.lfsr_q !== SEED0) begin n_fail++; $display("FAIL reseed_zero_lfsr: got %h want %h", dut.lfsr_q, SEED0); end
        tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL reseed_data_valid: got %b want 1", out_valid); end
        n_cmp++; if ({sh3, sh2, sh1} !== xor_model(t)) begin n_fail++; $display("FAIL reseed_data_shares: got %h want %h", {sh3, sh2, sh1}, xor_model(t)); end
        seed      = 32'h1;
        seed_load = 1'b1;
        tick;
        seed_load = 1'b0;
        n_cmp++; if (rand_out !== 12'h001) begin n_fail++; $display("FAIL reseed_one_rand: got %h want 001", rand_out); end
        in_terms = '0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        sw_lfsr  = 32'h8020_0003;
        n_cmp++; if (rand_out !== 12'h003) begin n_fail++; $display("FAIL reseed_step_rand: got %h want 003", rand_out); end
        tick;
        tick;
    endtask

    task automatic test_reset_midflight;
        logic [9*NC-1:0] t;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_terms  = 36'h1_1111_1111;
        tick;
        in_terms  = 36'h2_2222_2222;
        tick;
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (dut.lfsr_q !== SEED0) begin n_fail++; $display("FAIL midrst_lfsr: got %h want %h", dut.lfsr_q, SEED0); end
        tick;
        rst_n   = 1'b1;
        sw_lfsr = SEED0;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale%0d: got %b want 0", c, out_valid); end
        end
        t        = 36'h0_0000_01C7;
        in_terms = t;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        sw_lfsr  = lfsr_step(sw_lfsr);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_cycle1_valid: got %b want 0", out_valid); end
        tick;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL postrst_cycle2_valid: got %b want 1", out_valid); end
        n_cmp++; if ({sh3, sh2, sh1} !== {4'b0001, 4'b0000, 4'b0001}) begin n_fail++; $display("FAIL postrst_shares: got %h want 101", {sh3, sh2, sh1}); end
        n_cmp++; if (rand_out !== sw_lfsr[11:0]) begin n_fail++; $display("FAIL postrst_rand: got %h want %h", rand_out, sw_lfsr[11:0]); end
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_patterns;
        test_stall;
        test_back_to_back;
        test_reseed;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
